// File: rtl/mem_access_ctrl.sv
// LC-3 memory-access sequencer: steps MAR select/load, MDR capture and the memory
// enable/write strobes for one request, with a bounded wait on mem_rdy.
module mem_access_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic rw,
  input  logic vec,
  input  logic mem_rdy,
  output logic selMAR,
  output logic ldMAR,
  output logic ldMDR,
  output logic selMDR,
  output logic memEN,
  output logic memWE,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAR  = 3'd1,
    ACC  = 3'd2,
    CAP  = 3'd3,
    DONE = 3'd4
  } stateT;

  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  stateT         stateReg, stateNext;
  logic [CW-1:0] cntReg, cntNext;
  logic          rwReg, rwNext;
  logic          vecReg, vecNext;
  logic          errReg, errNext;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= IDLE;
      cntReg   <= '0;
      rwReg    <= 1'b0;
      vecReg   <= 1'b0;
      errReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      rwReg    <= rwNext;
      vecReg   <= vecNext;
      errReg   <= errNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    rwNext    = rwReg;
    vecNext   = vecReg;
    errNext   = errReg;
    selMAR    = 1'b0;
    ldMAR     = 1'b0;
    ldMDR     = 1'b0;
    selMDR    = 1'b0;
    memEN     = 1'b0;
    memWE     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;

    case (stateReg)
      IDLE: begin
        if (req) begin
          rwNext    = rw;
          vecNext   = vec;
          stateNext = MAR;
        end
      end

      MAR: begin
        busy   = 1'b1;
        selMAR = vecReg;
        ldMAR  = 1'b1;
        // Writes grab the store data from the bus while the address is loaded.
        if (rwReg) begin
          ldMDR  = 1'b1;
          selMDR = 1'b0;
        end
        cntNext   = '0;
        stateNext = ACC;
      end

      ACC: begin
        busy   = 1'b1;
        selMAR = vecReg;
        memEN  = 1'b1;
        memWE  = rwReg;
        // A ready in the last allowed cycle still wins over the timeout.
        if (mem_rdy) begin
          if (rwReg) begin
            errNext   = 1'b0;
            stateNext = DONE;
          end else begin
            stateNext = CAP;
          end
        end else if (cntReg == LAST_WAIT) begin
          errNext   = 1'b1;
          stateNext = DONE;
        end else begin
          cntNext = cntReg + CW'(1);
        end
      end

      CAP: begin
        busy      = 1'b1;
        selMAR    = vecReg;
        memEN     = 1'b1;
        ldMDR     = 1'b1;
        selMDR    = 1'b1;
        errNext   = 1'b0;
        stateNext = DONE;
      end

      DONE: begin
        busy      = 1'b1;
        selMAR    = vecReg;
        done      = 1'b1;
        err       = errReg;
        stateNext = IDLE;
      end

      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomised bench for mem_access_ctrl: stimulus pushes per-access expectations
// derived from cycle-count rules; a negedge monitor tallies strobes and compares on done.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
  localparam int T = 4;

  logic clk = 1'b0;
  logic reset = 1'b1, req = 1'b0, rw = 1'b0, vec = 1'b0, mem_rdy = 1'b0;
  logic selMAR, ldMAR, ldMDR, selMDR, memEN, memWE, busy, done, err;

  mem_access_ctrl #(.TIMEOUT(T), .CW(3)) dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .vec(vec), .mem_rdy(mem_rdy),
    .selMAR(selMAR), .ldMAR(ldMAR), .ldMDR(ldMDR), .selMDR(selMDR),
    .memEN(memEN), .memWE(memWE), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int doneCyc;
    int errExp;
    int busyCnt;
    int ldMar;
    int selMar;
    int en;
    int we;
    int cap;
    int bus;
    int rwExp;
  } expT;

  expT q[$];
  expT cur;
  int  checks = 0, errors = 0, nTxn = 0;
  bit  endReq = 1'b0, monDone = 1'b0, prevDone = 1'b0;
  int  aBusy, aLdMar, aSelMar, aEn, aWe, aCap, aBus;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clr();
    aBusy = 0; aLdMar = 0; aSelMar = 0; aEn = 0; aWe = 0; aCap = 0; aBus = 0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      clr();
      prevDone = 1'b0;
    end else begin
      chk("we_outside_acc", int'(memWE && !(memEN && busy)), 0);
      chk("done_consecutive", int'(done && prevDone), 0);
      if (busy) begin
        aBusy++;
        aLdMar  += int'(ldMAR);
        aSelMar += int'(selMAR);
        aEn     += int'(memEN);
        aWe     += int'(memWE);
        aCap    += int'(ldMDR && selMDR);
        aBus    += int'(ldMDR && !selMDR);
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          cur = q.pop_front();
          nTxn++;
          chk("done_cycle", cyc, cur.doneCyc);
          chk("err", int'(err), cur.errExp);
          chk("busy_cycles", aBusy, cur.busyCnt);
          chk("ldMAR_cycles", aLdMar, cur.ldMar);
          chk("selMAR_cycles", aSelMar, cur.selMar);
          chk("memEN_cycles", aEn, cur.en);
          chk("memWE_cycles", aWe, cur.we);
          chk("mdr_mem_loads", aCap, cur.cap);
          chk("mdr_bus_loads", aBus, cur.bus);
          $display("txn %0d rw=%0d err=%0d done@%0d en=%0d we=%0d", nTxn, cur.rwExp,
                   int'(err), cyc, aEn, aWe);
        end
        clr();
      end else if (!busy) begin
        chk("idle_outputs",
            int'({selMAR, ldMAR, ldMDR, selMDR, memEN, memWE, busy, done, err}), 0);
        clr();
      end
      prevDone = done;
    end
    if (endReq && !monDone) begin
      chk("pending_txns", q.size(), 0);
      monDone = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // k = ACC cycle (1-based) in which mem_rdy is presented; k > T means never.
  task automatic runTxn(input bit trw, input bit tvec, input int k, input bit hold);
    expT e;
    int  len, lim;
    if (k <= T) begin
      if (!trw) begin
        len = k + 3; e.en = k + 1; e.we = 0; e.cap = 1; e.bus = 0;
      end else begin
        len = k + 2; e.en = k; e.we = k; e.cap = 0; e.bus = 1;
      end
      e.errExp = 0;
    end else begin
      len = T + 2; e.en = T; e.we = trw ? T : 0; e.cap = 0; e.bus = int'(trw);
      e.errExp = 1;
    end
    lim       = (k < T) ? k : T;
    e.busyCnt = len;
    e.ldMar   = 1;
    e.selMar  = tvec ? len : 0;
    e.rwExp   = int'(trw);
    e.doneCyc = cyc + 1 + len - 1;
    q.push_back(e);
    req = 1'b1; rw = trw; vec = tvec; mem_rdy = rbit();
    for (int j = 0; j <= len; j++) begin
      tick();
      rw  = rbit();
      vec = rbit();
      if (j >= 1 && j <= lim) mem_rdy = (j == k);
      else                    mem_rdy = rbit();
      req = (j < len) ? (hold ? 1'b1 : rbit()) : 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req = 1'b0; rw = rbit(); vec = rbit(); mem_rdy = rbit();
      tick();
    end
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    idle(5);

    // Directed: basic read, write with late ready, timeouts, ready on last cycle.
    runTxn(1'b0, 1'b0, 1, 1'b0);
    idle(1);
    runTxn(1'b1, 1'b1, 4, 1'b0);
    idle(1);
    runTxn(1'b0, 1'b0, T + 3, 1'b0);
    runTxn(1'b0, 1'b1, T, 1'b0);
    runTxn(1'b1, 1'b0, T + 1, 1'b0);
    idle(2);

    // Reset during the second ACC cycle of a write: no done may follow.
    req = 1'b1; rw = 1'b1; vec = 1'b1; mem_rdy = 1'b0;
    tick();
    req = 1'b0; mem_rdy = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(T + 4);
    runTxn(1'b0, 1'b1, 2, 1'b0);

    // Back-to-back with req held high throughout.
    for (int i = 0; i < 6; i++)
      runTxn(rbit(), rbit(), $urandom_range(1, T + 2), 1'b1);
    idle(2);

    // Randomised accesses with random gaps.
    for (int i = 0; i < 150; i++) begin
      runTxn(rbit(), rbit(), $urandom_range(1, T + 2), rbit());
      idle($urandom_range(0, 2));
    end

    idle(3);
    endReq = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
